// File: rtl/gate_tt_walker.sv
// Truth-table walker: steps through every {a, b} operand pair, applies the
// latched bitwise gate and streams {idx, a, b, y} rows with a running ones total.
module gate_tt_walker #(
    parameter  int WIDTH = 2,
    localparam int IW    = 2 * WIDTH,
    localparam int CW    = IW + $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IW-1:0]    out_idx,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_y,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    ones_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (m)
            3'd0:    r = a;
            3'd1:    r = ~a;
            3'd2:    r = a & b;
            3'd3:    r = ~(a & b);
            3'd4:    r = a | b;
            3'd5:    r = ~(a | b);
            3'd6:    r = a ^ b;
            3'd7:    r = ~(a ^ b);
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [2:0]        mode_q, mode_d;
    logic [CW-1:0]     ones_q, ones_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  y_s;

    // Gate result from the registered index and latched mode; after reset this is BUF of 0.
    always_comb begin
        y_s = gate_eval(mode_q, idx_q[IW-1:WIDTH], idx_q[WIDTH-1:0]);
    end

    // Next-state and registered-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        ones_d  = ones_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    idx_d   = {IW{1'b0}};
                    ones_d  = {CW{1'b0}};
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (valid_q && out_ready) begin
                    ones_d = ones_q + popcount(y_s);
                    if (idx_q == LAST_IDX) begin
                        // idx stays on the last row; out_y is a don't-care once valid drops
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            mode_q  <= 3'd0;
            ones_q  <= {CW{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_a      = idx_q[IW-1:WIDTH];
    assign out_b      = idx_q[WIDTH-1:0];
    assign out_y      = y_s;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_gate_tt_walker.sv
// Directed bench for gate_tt_walker (WIDTH=2): table of runs and hand-computed rows,
// plus sequences for back-pressure, ignored start/mode and reset mid-run.
module tb_gate_tt_walker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] mode;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_idx;
    logic [1:0] out_a;
    logic [1:0] out_b;
    logic [1:0] out_y;
    logic       busy;
    logic       done;
    logic [5:0] ones_count;

    int checks   = 0;
    int failures = 0;

    logic [1:0] cap_a [16];
    logic [1:0] cap_b [16];
    logic [1:0] cap_y [16];

    typedef struct {
        logic [2:0] mode;
        int         stall_at;
        int         stall_len;
        int         poke_at;
        int         exp_ones;
    } run_vec_t;

    typedef struct {
        int         run;
        int         idx;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic [1:0] exp_y;
    } row_vec_t;

    run_vec_t runs [10];
    row_vec_t rows_tab [11];

    gate_tt_walker #(.WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_y      (out_y),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_gate(input logic [2:0] m, input logic [1:0] a, input logic [1:0] b);
        case (m)
            3'd0:    return a;
            3'd1:    return ~a;
            3'd2:    return a & b;
            3'd3:    return ~(a & b);
            3'd4:    return a | b;
            3'd5:    return ~(a | b);
            3'd6:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_a"},     32'(out_a),     32'd0);
        chk({tag, "_b"},     32'(out_b),     32'd0);
        chk({tag, "_y"},     32'(out_y),     32'd0);
        chk({tag, "_ones"},  32'(ones_count), 32'd0);
    endtask

    // Called on a negedge with the block idle; returns on a negedge, idle again.
    task automatic do_run(input logic [2:0] m, input int stall_at, input int stall_len,
                          input int poke_at, input int exp_ones);
        int rows, cyc, last_xfer, done_cyc, done_cnt, stall_cnt, model_ones;
        bit poked;
        logic [1:0] ea, eb, ey;
        chk("pre_start_valid", 32'(out_valid), 32'd0);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_busy",  32'(busy),      32'd1);
        rows = 0; cyc = 0; last_xfer = -10; done_cyc = -1; done_cnt = 0;
        stall_cnt = 0; model_ones = 0; poked = 1'b0;
        while (cyc < 300 && !(rows == 16 && cyc > last_xfer + 2)) begin
            start     = 1'b0;
            out_ready = 1'b1;
            if (rows < 16) chk("no_bubble", 32'(out_valid), 32'd1);
            if (out_valid && stall_len > 0 && int'(out_idx) == stall_at && stall_cnt < stall_len) begin
                out_ready = 1'b0;
                stall_cnt++;
                ea = out_idx[3:2];
                eb = out_idx[1:0];
                ey = ref_gate(m, ea, eb);
                chk("stall_idx", 32'(out_idx), 32'(stall_at));
                chk("stall_row", 32'({out_a, out_b, out_y}), 32'({ea, eb, ey}));
            end
            if (poke_at >= 0 && !poked && out_valid && int'(out_idx) == poke_at) begin
                start = 1'b1;
                mode  = 3'd6;
                poked = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_busy",  32'(busy),       32'd0);
                chk("done_valid", 32'(out_valid),  32'd0);
                chk("done_ones",  32'(ones_count), 32'(exp_ones));
            end
            if (out_valid && out_ready) begin
                ea = rows[3:0] >> 2;
                eb = rows[1:0];
                ey = ref_gate(m, ea, eb);
                chk("row_idx", 32'(out_idx), 32'(rows));
                chk("row_ab",  32'({out_a, out_b}), 32'({ea, eb}));
                chk("row_y",   32'(out_y), 32'(ey));
                cap_a[rows] = out_a;
                cap_b[rows] = out_b;
                cap_y[rows] = out_y;
                model_ones += int'(ey[0]) + int'(ey[1]);
                rows++;
                last_xfer = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("row_count",   32'(rows),       32'd16);
        chk("done_count",  32'(done_cnt),   32'd1);
        chk("done_timing", 32'(done_cyc),   32'(last_xfer + 1));
        chk("ones_model",  32'(model_ones), 32'(exp_ones));
        chk("ones_held",   32'(ones_count), 32'(exp_ones));
        chk("idle_valid",  32'(out_valid),  32'd0);
        chk("idle_busy",   32'(busy),       32'd0);
        if (stall_len > 0) chk("stall_cycles", 32'(stall_cnt), 32'(stall_len));
    endtask

    initial begin
        // mode, stall_at, stall_len, poke_at, expected ones_count
        runs[0] = '{3'd3, -1, 0, -1, 24};   // NAND
        runs[1] = '{3'd7, -1, 0, -1, 16};   // XNOR
        runs[2] = '{3'd0, -1, 0, -1, 16};   // BUF
        runs[3] = '{3'd2, -1, 0, -1,  8};   // AND
        runs[4] = '{3'd3,  5, 3, -1, 24};   // NAND with back-pressure at idx 5
        runs[5] = '{3'd3, -1, 0,  9, 24};   // NAND with start/mode poke at idx 9
        runs[6] = '{3'd4, -1, 0, -1, 24};   // OR
        runs[7] = '{3'd5, -1, 0, -1,  8};   // NOR
        runs[8] = '{3'd6, -1, 0, -1, 16};   // XOR
        runs[9] = '{3'd1, -1, 0, -1, 16};   // NOT

        rows_tab[0]  = '{0,  6, 2'b01, 2'b10, 2'b11};
        rows_tab[1]  = '{1,  6, 2'b01, 2'b10, 2'b00};
        rows_tab[2]  = '{1,  5, 2'b01, 2'b01, 2'b11};
        rows_tab[3]  = '{2,  9, 2'b10, 2'b01, 2'b10};
        rows_tab[4]  = '{3, 15, 2'b11, 2'b11, 2'b11};
        rows_tab[5]  = '{4,  5, 2'b01, 2'b01, 2'b10};
        rows_tab[6]  = '{5, 12, 2'b11, 2'b00, 2'b11};
        rows_tab[7]  = '{6,  6, 2'b01, 2'b10, 2'b11};
        rows_tab[8]  = '{7,  0, 2'b00, 2'b00, 2'b11};
        rows_tab[9]  = '{8,  6, 2'b01, 2'b10, 2'b11};
        rows_tab[10] = '{9,  4, 2'b01, 2'b00, 2'b10};

        rst_n = 1'b0; start = 1'b0; mode = 3'd0; out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            start = (i == 2) ? 1'b1 : 1'b0;
            mode  = 3'd3;
            @(negedge clk);
            check_zero("reset");
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_zero("idle");
        end

        out_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            do_run(runs[r].mode, runs[r].stall_at, runs[r].stall_len, runs[r].poke_at, runs[r].exp_ones);
            for (int k = 0; k < 11; k++) begin
                if (rows_tab[k].run == r) begin
                    chk("tab_a", 32'(cap_a[rows_tab[k].idx]), 32'(rows_tab[k].exp_a));
                    chk("tab_b", 32'(cap_b[rows_tab[k].idx]), 32'(rows_tab[k].exp_b));
                    chk("tab_y", 32'(cap_y[rows_tab[k].idx]), 32'(rows_tab[k].exp_y));
                end
            end
            @(negedge clk);
        end

        // Reset in the middle of a run at idx 10
        mode  = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && out_idx != 4'd10; i++) @(negedge clk);
        chk("midrst_reach_idx10", 32'(out_idx), 32'd10);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_zero("midrst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_wait_valid", 32'(out_valid), 32'd0);
            chk("midrst_wait_done",  32'(done),      32'd0);
        end
        do_run(3'd3, -1, 0, -1, 24);
        chk("restart_row0_y", 32'(cap_y[0]), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_tt_walker.md
Name: gate_tt_walker

Overview:
- Sequential, parametrised successor to the gate-level truth-table exercises.
- Enumerates every combination of two WIDTH-bit operands in hardware.
- Applies a run-time selectable bitwise gate function: BUF, NOT, AND, NAND, OR, NOR, XOR or XNOR.
- Streams each {a, b, y} row out on a valid/ready interface and reports a per-run count of result ones.
- Sits beside the gate exercises as the self-checking truth-table source for benches and display logic.

Parameters:
- WIDTH, 2, operand/result width in bits; legal range 1..4.
- Localparam IW = 2*WIDTH, row index width.
- Localparam CW = IW + $clog2(WIDTH) + 1, ones_count width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- mode  in  3  gate select, latched on accepted start: 0 BUF(y=a), 1 NOT(y=~a), 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR
- out_ready  in  1  downstream accepts the current row
- out_valid  out  1  row fields are valid
- out_idx  out  IW  row index, 0 .. 2^IW-1
- out_a  out  WIDTH  operand a = out_idx[IW-1:WIDTH]
- out_b  out  WIDTH  operand b = out_idx[WIDTH-1:0]
- out_y  out  WIDTH  bitwise gate result of out_a, out_b under the latched mode
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run
- ones_count  out  CW  total ones in out_y over all accepted rows of the current or last run

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low: clock port clk, reset port rst_n.
- Reset state: rst_n low forces state IDLE and clears all outputs to 0 immediately, including the latched mode and ones_count.
- Reset mid-run: abandons the run with no done pulse. After release the block waits for a new start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge n latches mode, sets idx=0, clears ones_count and enters RUN.
  - out_valid=1 and busy=1 from cycle n+1, so there is 1 cycle of latency.
- RUN, transfer: a transfer occurs on an edge where out_valid and out_ready are both 1.
  - ones_count += popcount(out_y) for the transferred row.
  - If idx != 2^IW-1: idx increments, and the next row is valid in the next cycle with no bubble.
  - If idx == 2^IW-1: go to DONE; out_valid and busy drop in the next cycle.
- RUN, back-pressure: with out_valid=1 and out_ready=0, out_idx, out_a, out_b and out_y hold stable. There is no limit on how long the block stalls.
- DONE: lasts exactly one cycle.
  - done=1; ones_count holds the final total.
  - Next state is IDLE. ones_count stays held in IDLE until the next accepted start.
- start handling: ignored in RUN and DONE, with no queuing.
- mode handling: mode changes after the accepted start have no effect until the next run.
- out_y is combinational from the registered idx and the latched mode. All other outputs are registered.
- Arithmetic: ones_count is unsigned and sized so that WIDTH*2^IW cannot overflow.
- out_y is a don't-care when out_valid=0, but it must be driven (no x/z once out of reset).
- Simultaneous start and rst_n low: reset wins.

Test Plan:
- Reset and idle: rst_n low for 3 cycles, then start=0 for 5 cycles. All outputs must be 0, busy=0 and done=0.
- NAND run, WIDTH=2, mode=3, out_ready=1:
  - Exactly 16 consecutive valid rows.
  - Row idx=6 gives a=01, b=10, y=11.
  - done pulses one cycle after the idx=15 transfer.
  - ones_count=24.
- XNOR run, mode=7: row idx=6 gives y=00 and row idx=5 gives y=11. Final ones_count=16. BUF run, mode=0: final ones_count=16. AND run, mode=2: final ones_count=8.
- Back-pressure: during a NAND run, hold out_ready=0 for 3 cycles at idx=5. Row fields must stay a=01, b=01, y=10, and the final ones_count must still be 24 (no double count).
- Ignored inputs: pulse start and change mode to 6 mid-run at idx=9. The run must continue with the original mode and produce a single done pulse.
- Reset mid-run: drop rst_n at idx=10. Outputs must go to 0 asynchronously, before the next clock edge, with no done pulse. A fresh start must then restart from idx=0.
